// File: rtl/mc_control_if.sv
// mc_control_if
//   Shared instruction/data memory port between the multi-cycle control FSM
//   and the memory. The controller owns the request side; memory answers
//   with a single-cycle acknowledge.
//
//   mem_req  : request is active (held until mem_ack)
//   mem_we   : write request, qualified by mem_req
//   iord     : address select, 0 = PC, 1 = ALU result register
//   mem_ack  : memory completes the pending request this cycle
//
//   Modports: master (controller side), slave (memory side).
interface mc_control_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output iord, input mem_ack);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mc_control.sv
// mc_control
//   Multi-cycle control FSM for the MIPS datapath. Walks each instruction
//   through FETCH, DECODE, EXEC, MEM and WB, drives every datapath enable
//   and mux select, and owns the shared memory port through a req/ack
//   handshake guarded by a bounded wait counter (bus error on timeout).
//
//   Parameters: WAIT_LIMIT (max cycles waiting for mem_ack), WAIT_W (counter
//   width, 2**WAIT_W > WAIT_LIMIT).
//
//   Ports:
//     clk, rst_n              clock (rising edge), async active-low reset
//     op, funct, bit16        decoded IR fields
//     zero, neg               ALU flags, valid in EXEC
//     mem                     memory handshake (mc_control_if.master)
//     ir_write, pc_write      IR / PC load strobes
//     pc_src, alu_srcb, alu_op, reg_write, reg_dst, mem_to_reg
//                             datapath selects and register file write
//     illegal                 one-cycle pulse on an unsupported encoding
//     bus_err                 sticky memory timeout flag
//
//   Build option: define MC_CONTROL_REGIMM_EN to accept op 0x01
//   (bltz/bgez selected by bit16). Without it op 0x01 decodes as illegal.
module mc_control #(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                bit16,
    input  logic                zero,
    input  logic                neg,
    mc_control_if.master        mem,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_srcb,
    output logic [3:0]          alu_op,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                illegal,
    output logic                bus_err
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;

    typedef enum logic [4:0] {
        C_ADDU, C_SUBU, C_AND, C_OR, C_SLT, C_SLL, C_SRL, C_JR,
        C_ADDIU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL,
        C_BLTZ, C_BGEZ, C_ILL
    } iclass_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t              state_q, state_d;
    iclass_t             cls_q, cls_d, dec_cls, next_cls;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bus_err_q, bus_err_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic                iord_q, iord_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic [1:0]          alu_srcb_q, alu_srcb_d;
    logic                reg_write_q, reg_write_d;
    logic [1:0]          reg_dst_q, reg_dst_d;
    logic [1:0]          mem_to_reg_q, mem_to_reg_d;
    logic                taken, wait_hit, fetch_done;

`ifndef MC_CONTROL_REGIMM_EN
    logic unused_regimm;
    assign unused_regimm = bit16 ^ neg;
`endif

    // Instruction classification from the live IR fields (used in DECODE).
    always_comb begin
        dec_cls = C_ILL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   dec_cls = C_ADDU;
                    6'h23:   dec_cls = C_SUBU;
                    6'h24:   dec_cls = C_AND;
                    6'h25:   dec_cls = C_OR;
                    6'h2A:   dec_cls = C_SLT;
                    6'h00:   dec_cls = C_SLL;
                    6'h02:   dec_cls = C_SRL;
                    6'h08:   dec_cls = C_JR;
                    default: dec_cls = C_ILL;
                endcase
            end
`ifdef MC_CONTROL_REGIMM_EN
            6'h01:   dec_cls = bit16 ? C_BGEZ : C_BLTZ;
`endif
            6'h09:   dec_cls = C_ADDIU;
            6'h0D:   dec_cls = C_ORI;
            6'h0F:   dec_cls = C_LUI;
            6'h23:   dec_cls = C_LW;
            6'h2B:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h05:   dec_cls = C_BNE;
            6'h02:   dec_cls = C_J;
            6'h03:   dec_cls = C_JAL;
            default: dec_cls = C_ILL;
        endcase
    end

    // Branch condition, evaluated against the ALU flags during EXEC.
    always_comb begin
        taken = 1'b0;
        case (cls_q)
            C_BEQ:   taken = zero;
            C_BNE:   taken = !zero;
`ifdef MC_CONTROL_REGIMM_EN
            C_BLTZ:  taken = neg;
            C_BGEZ:  taken = !neg;
`endif
            default: taken = 1'b0;
        endcase
    end

    // The first cycle after reset sits in FETCH with no request yet, so
    // completion and wait counting are both qualified by the live request.
    assign fetch_done = (state_q == FETCH) && mem_req_q && mem.mem_ack;
    assign wait_hit   = mem_req_q && !mem.mem_ack && (wait_cnt_q == WAIT_LAST);

    // Next state, wait counter, latched instruction class and bus error.
    always_comb begin
        state_d   = state_q;
        next_cls  = (state_q == DECODE) ? dec_cls : cls_q;
        cls_d     = next_cls;
        case (state_q)
            FETCH: begin
                if (fetch_done)    state_d = DECODE;
                else if (wait_hit) state_d = ERR;
            end
            DECODE: state_d = (dec_cls == C_ILL) ? FETCH : EXEC;
            EXEC: begin
                case (cls_q)
                    C_LW, C_SW:                          state_d = MEM;
                    C_ADDU, C_SUBU, C_AND, C_OR, C_SLT,
                    C_SLL, C_SRL, C_ADDIU, C_ORI, C_LUI: state_d = WB;
                    default:                             state_d = FETCH;
                endcase
            end
            MEM: begin
                if (mem.mem_ack)   state_d = (cls_q == C_SW) ? FETCH : WB;
                else if (wait_hit) state_d = ERR;
            end
            WB:      state_d = FETCH;
            ERR:     state_d = ERR;
            default: state_d = FETCH;
        endcase

        // Any state change restarts the count, which covers entry into
        // FETCH and MEM; ack on the limit cycle is handled above.
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_req_q && !mem.mem_ack)
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        else
            wait_cnt_d = wait_cnt_q;

        bus_err_d = bus_err_q || (state_d == ERR);
    end

    // Moore outputs are registered from the next state so they line up
    // with the state they belong to and clear immediately on reset.
    always_comb begin
        mem_req_d    = (state_d == FETCH) || (state_d == MEM);
        iord_d       = (state_d == MEM);
        mem_we_d     = (state_d == MEM) && (next_cls == C_SW);
        alu_op_d     = 4'd0;
        alu_srcb_d   = 2'd0;
        reg_write_d  = 1'b0;
        reg_dst_d    = 2'd0;
        mem_to_reg_d = 2'd0;
        if (state_d == EXEC) begin
            case (next_cls)
                C_SUBU:      alu_op_d = 4'd1;
                C_AND:       alu_op_d = 4'd2;
                C_OR:        alu_op_d = 4'd3;
                C_SLT:       alu_op_d = 4'd4;
                C_SLL:       alu_op_d = 4'd5;
                C_SRL:       alu_op_d = 4'd6;
                C_ADDIU, C_LW, C_SW: alu_srcb_d = 2'd1;
                C_ORI: begin
                    alu_op_d   = 4'd3;
                    alu_srcb_d = 2'd2;
                end
                C_LUI:       alu_srcb_d = 2'd3;
                C_BEQ, C_BNE: alu_op_d = 4'd1;
                C_JAL: begin
                    reg_write_d  = 1'b1;
                    reg_dst_d    = 2'd2;
                    mem_to_reg_d = 2'd2;
                end
                default:     alu_op_d = 4'd0;
            endcase
        end
        if (state_d == WB) begin
            reg_write_d = 1'b1;
            case (next_cls)
                C_ADDU, C_SUBU, C_AND, C_OR, C_SLT, C_SLL, C_SRL: reg_dst_d = 2'd1;
                C_LW:    mem_to_reg_d = 2'd1;
                default: reg_dst_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            cls_q        <= C_ILL;
            wait_cnt_q   <= '0;
            bus_err_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            iord_q       <= 1'b0;
            alu_op_q     <= 4'd0;
            alu_srcb_q   <= 2'd0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 2'd0;
            mem_to_reg_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            wait_cnt_q   <= wait_cnt_d;
            bus_err_q    <= bus_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            iord_q       <= iord_d;
            alu_op_q     <= alu_op_d;
            alu_srcb_q   <= alu_srcb_d;
            reg_write_q  <= reg_write_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // Strobes that depend on mem_ack or the ALU flags in the same cycle.
    always_comb begin
        pc_src = 2'd0;
        if (state_q == EXEC) begin
            case (cls_q)
                C_BEQ, C_BNE, C_BLTZ, C_BGEZ: pc_src = 2'd1;
                C_J, C_JAL:                   pc_src = 2'd2;
                C_JR:                         pc_src = 2'd3;
                default:                      pc_src = 2'd0;
            endcase
        end
    end

    assign ir_write = fetch_done;
    assign pc_write = fetch_done ||
                      ((state_q == EXEC) &&
                       (taken || cls_q == C_J || cls_q == C_JAL || cls_q == C_JR));
    assign illegal  = (state_q == DECODE) && (dec_cls == C_ILL);

    assign mem.mem_req = mem_req_q;
    assign mem.mem_we  = mem_we_q;
    assign mem.iord    = iord_q;
    assign alu_op      = alu_op_q;
    assign alu_srcb    = alu_srcb_q;
    assign reg_write   = reg_write_q;
    assign reg_dst     = reg_dst_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
//   Directed bench for mc_control with WAIT_LIMIT = 4. Inputs change 1 ns
//   after each rising edge and outputs are compared 1 ns later.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       bit16, zero, neg;
    logic       ir_write, pc_write, reg_write, illegal, bus_err;
    logic [1:0] pc_src, alu_srcb, reg_dst, mem_to_reg;
    logic [3:0] alu_op;
    int         compared   = 0;
    int         mismatched = 0;

    mc_control_if mem_bus ();

    mc_control #(.WAIT_LIMIT(4), .WAIT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .bit16(bit16),
        .zero(zero), .neg(neg), .mem(mem_bus), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_srcb(alu_srcb),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input logic ack, input logic z);
        op = o;
        funct = f;
        mem_bus.mem_ack = ack;
        zero = z;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH with the request up: acknowledge immediately.
    task automatic doFetch(input logic [5:0] o, input logic [5:0] f);
        applyStimulus(o, f, 1'b1, 1'b0);
        checkOutput("fetch_ir_write", ir_write, 1);
        nextCycle();
        applyStimulus(o, f, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bit16 = 1'b0;
        neg = 1'b0;
        applyStimulus(6'h00, 6'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_mem_req", mem_bus.mem_req, 0);
        checkOutput("rst_strobes", {ir_write, pc_write, reg_write, illegal, bus_err}, 0);
        rst_n = 1'b1;
        nextCycle();

        // addu: ack one cycle after the request
        applyStimulus(6'h00, 6'h21, 1'b0, 1'b0);
        checkOutput("addu_req", {mem_bus.mem_req, mem_bus.iord, ir_write}, 8'b100);
        nextCycle();
        applyStimulus(6'h00, 6'h21, 1'b1, 1'b0);
        checkOutput("addu_fetch", {ir_write, pc_write, pc_src}, 8'b1100);
        nextCycle();
        applyStimulus(6'h00, 6'h21, 1'b0, 1'b0);
        checkOutput("addu_decode", {ir_write, mem_bus.mem_req, illegal}, 0);
        nextCycle();
        checkOutput("addu_exec", {alu_op, reg_write, pc_write}, 0);
        nextCycle();
        checkOutput("addu_wb", {reg_write, reg_dst, mem_to_reg}, 8'b10100);
        nextCycle();
        checkOutput("addu_refetch", {mem_bus.mem_req, reg_write}, 8'b10);

        // lw with the data ack delayed 3 cycles
        doFetch(6'h23, 6'h00);
        nextCycle();
        checkOutput("lw_exec", {alu_op, alu_srcb}, 8'b000001);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'h23, 6'h00, (i == 3), 1'b0);
            checkOutput($sformatf("lw_mem%0d", i), {mem_bus.mem_req, mem_bus.iord, mem_bus.mem_we}, 8'b110);
            nextCycle();
        end
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
        checkOutput("lw_wb", {reg_write, reg_dst, mem_to_reg, mem_bus.mem_req}, 8'b100010);
        nextCycle();

        // sw: single MEM cycle with write, then straight back to FETCH
        doFetch(6'h2B, 6'h00);
        nextCycle();
        nextCycle();
        applyStimulus(6'h2B, 6'h00, 1'b1, 1'b0);
        checkOutput("sw_mem", {mem_bus.mem_req, mem_bus.iord, mem_bus.mem_we}, 8'b111);
        nextCycle();
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
        checkOutput("sw_fetch", {mem_bus.mem_req, mem_bus.iord, mem_bus.mem_we, reg_write}, 8'b1000);

        // beq taken / not taken
        doFetch(6'h04, 6'h00);
        nextCycle();
        applyStimulus(6'h04, 6'h00, 1'b0, 1'b1);
        checkOutput("beq_t_exec", {pc_write, pc_src, alu_op}, 8'b1010001);
        nextCycle();
        checkOutput("beq_t_fetch", {mem_bus.mem_req, pc_write}, 8'b10);
        doFetch(6'h04, 6'h00);
        nextCycle();
        applyStimulus(6'h04, 6'h00, 1'b0, 1'b0);
        checkOutput("beq_nt_pc_write", pc_write, 0);
        nextCycle();
        checkOutput("beq_nt_fetch", mem_bus.mem_req, 1);

        // jal and jr
        doFetch(6'h03, 6'h00);
        nextCycle();
        checkOutput("jal_exec", {pc_write, pc_src, reg_write, reg_dst, mem_to_reg}, 8'b11011010);
        nextCycle();
        checkOutput("jal_fetch", {mem_bus.mem_req, reg_write}, 8'b10);
        doFetch(6'h00, 6'h08);
        nextCycle();
        checkOutput("jr_exec", {pc_write, pc_src, reg_write}, 8'b1110);
        nextCycle();

        // lui: immediate shifted into the upper half
        doFetch(6'h0F, 6'h00);
        nextCycle();
        checkOutput("lui_srcb", alu_srcb, 3);
        nextCycle();
        checkOutput("lui_wb", {reg_write, reg_dst, mem_to_reg}, 8'b10000);
        nextCycle();

        // unsupported opcode
        doFetch(6'h3F, 6'h00);
        checkOutput("ill_decode", {illegal, reg_write, mem_bus.mem_we}, 8'b100);
        nextCycle();
        checkOutput("ill_fetch", {illegal, mem_bus.mem_req}, 8'b01);

        // REGIMM opcode depends on the build option
        doFetch(6'h01, 6'h00);
`ifdef MC_CONTROL_REGIMM_EN
        checkOutput("regimm_decode", illegal, 0);
        nextCycle();
        checkOutput("bltz_nt_exec", pc_write, 0);
        nextCycle();
`else
        checkOutput("regimm_decode", illegal, 1);
        nextCycle();
`endif

        // ack on the 4th wait cycle still completes normally
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(6'h3F, 6'h00, 1'b1, 1'b0);
        checkOutput("late_ack_ir_write", {ir_write, bus_err}, 8'b10);
        nextCycle();
        applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0);
        nextCycle();

        // no ack at all: bus error after 4 wait cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0);
            checkOutput($sformatf("to_wait%0d", i), {mem_bus.mem_req, bus_err}, 8'b10);
            nextCycle();
        end
        checkOutput("err_entry", {bus_err, mem_bus.mem_req, ir_write, pc_write, reg_write}, 8'b10000);
        applyStimulus(6'h3F, 6'h00, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("err_held", {bus_err, mem_bus.mem_req, ir_write, pc_write}, 8'b1000);

        // reset clears the sticky error
        rst_n = 1'b0;
        #1;
        checkOutput("err_reset", bus_err, 0);
        applyStimulus(6'h00, 6'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        nextCycle();

        // reset in the middle of a MEM wait abandons the request
        doFetch(6'h23, 6'h00);
        nextCycle();
        nextCycle();
        checkOutput("mid_mem_req", {mem_bus.mem_req, mem_bus.iord}, 8'b11);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_mem_reset", {mem_bus.mem_req, mem_bus.iord, bus_err}, 0);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("post_reset_fetch", {mem_bus.mem_req, mem_bus.iord}, 8'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Consumes decoded instruction fields (op, funct, bit16) from the instruction field splitter. Sequences fetch, decode, execute, memory and writeback one instruction at a time.
- Drives every datapath enable and mux select.
- Owns the shared instruction/data memory port through a req/ack handshake with a bounded wait counter.

Parameters:
- WAIT_LIMIT, 255: maximum cycles to wait for mem_ack before flagging a bus error.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode field of the current IR.
- funct  in  6  function field of the current IR.
- bit16  in  1  IR bit 16 (REGIMM selector).
- zero  in  1  ALU zero flag, valid in EXEC.
- neg  in  1  ALU result sign, valid in EXEC.
- mem_ack  in  1  memory completes the request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request, qualified by mem_req.
- iord  out  1  address mux: 0 = PC, 1 = ALU result register.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- alu_srcb  out  2  0 = rt, 1 = sign-ext imm, 2 = zero-ext imm, 3 = imm<<16.
- alu_op  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 srl.
- reg_write  out  1  register file write.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31.
- mem_to_reg  out  2  0 = ALU, 1 = memory data, 2 = PC+4 (link).
- illegal  out  1  pulse: unsupported encoding decoded.
- bus_err  out  1  sticky: memory wait exceeded WAIT_LIMIT.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, ERR. Reset enters FETCH.
- All outputs are Moore or Mem_ack-qualified. Reset values are 0 for all outputs; bus_err is 0 at reset.
- FETCH:
  - mem_req=1, iord=0.
  - On mem_ack: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: no strobes; one cycle; classify op/funct, then go to EXEC.
- Supported encodings:
  - R-type (op 0) funct: addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
  - I/J-type op: addiu 0x09, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- Illegal encoding: in DECODE, illegal=1 for one cycle, then go to FETCH; no register or memory writes occur.
- EXEC: set alu_op and alu_srcb per instruction.
  - ALU ops go to WB.
  - lw and sw go to MEM.
  - beq: if zero, pc_write=1, pc_src=1; then FETCH.
  - bne: if !zero, pc_write=1, pc_src=1; then FETCH.
  - j: pc_write=1, pc_src=2; then FETCH.
  - jr: pc_write=1, pc_src=3; then FETCH.
  - jal: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; then FETCH.
- MEM: mem_req=1, iord=1, mem_we=1 for sw.
  - On mem_ack: sw goes to FETCH; lw goes to WB.
- WB: reg_write=1 for one cycle, then FETCH.
  - R-type: reg_dst=1, mem_to_reg=0.
  - I-type ALU: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
- Latency: fetch completes on the ack cycle. Excluding wait cycles:
  - ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jump: 3 cycles.
- Wait counter:
  - Clears on entering FETCH or MEM; increments each cycle mem_req=1 && !mem_ack.
  - If it reaches WAIT_LIMIT without ack: go to ERR, set bus_err=1.
  - mem_ack on the same cycle the limit is reached wins: normal completion, no error.
- ERR: all strobes 0, mem_req=0; held until reset.
- mem_req stays asserted and mem_we stays stable until mem_ack; no request is withdrawn before ack.
- Asynchronous reset mid-operation returns the FSM to FETCH, counter to 0, bus_err to 0. An in-flight request is abandoned.

Optional Feature:
- MC_CONTROL_REGIMM_EN defined: op 0x01 is legal.
  - bit16=0 is bltz, taken if neg.
  - bit16=1 is bgez, taken if !neg.
  - Taken: pc_write=1, pc_src=1 in EXEC, then FETCH.
- MC_CONTROL_REGIMM_EN undefined: op 0x01 is illegal (illegal pulse, return to FETCH).

Test Plan:
- Reset, then addu (op 0, funct 0x21) with mem_ack in the cycle after req → ir_write 1 cycle; reg_write=1, reg_dst=1 exactly in cycle 4 after ack; pc_src=0.
- lw (op 0x23) with data ack delayed 3 cycles → MEM holds mem_req=1, iord=1, mem_we=0 for 4 cycles; then WB with mem_to_reg=1.
- beq: zero=1 → pc_write with pc_src=1 in EXEC. beq: zero=0 → no pc_write in EXEC. Both return to FETCH.
- jal → single EXEC cycle with pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2.
- op 0x3F → illegal pulses 1 cycle in DECODE; no reg_write/mem_we; next state FETCH.
- WAIT_LIMIT=4, mem_ack held 0 → bus_err=1 after 4 wait cycles, outputs 0, stays in ERR. Separate run with mem_ack arriving on the 4th wait cycle → no error.
- Reset asserted mid-MEM → mem_req drops asynchronously; after release, FETCH with mem_req=1.
